// File: rtl/mem_responder.sv
// Single-outstanding line memory model: accepts one line read or write at a time,
// answers reads with BEATS beats after a fixed latency, applies byte masks on writes.
module mem_responder #(
    parameter int ADDR_BITS = 28,
    parameter int DATA_BITS = 128,
    parameter int TAG_BITS  = 5,
    parameter int BEATS     = 4,
    parameter int LATENCY   = 8,
    parameter int DEPTH     = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mem_req_valid,
    output logic                   mem_req_ready,
    input  logic                   mem_req_rw,
    input  logic [ADDR_BITS-1:0]   mem_req_addr,
    input  logic [TAG_BITS-1:0]    mem_req_tag,
    input  logic                   mem_req_data_valid,
    output logic                   mem_req_data_ready,
    input  logic [DATA_BITS-1:0]   mem_req_data_bits,
    input  logic [DATA_BITS/8-1:0] mem_req_data_mask,
    output logic                   mem_resp_valid,
    output logic [DATA_BITS-1:0]   mem_resp_data,
    output logic [TAG_BITS-1:0]    mem_resp_tag
);

    localparam int BEAT_W = $clog2(BEATS);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int LAT_W  = $clog2(LATENCY) + 1;
    localparam int BYTES  = DATA_BITS / 8;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    // The first beat is registered one cycle before it is seen, hence LATENCY-2.
    localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(LATENCY - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        RWAIT = 2'd2,
        RRESP = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic                   accept_s;
    logic                   wr_beat_s;
    logic [BEAT_W-1:0]      rd_beat_s;
    logic [IDX_W-1:0]       rd_idx_s;
    logic [IDX_W-1:0]       wr_idx_s;
    logic [ADDR_BITS-1:0]   addr_r;
    logic [TAG_BITS-1:0]    tag_r;
    logic [BEAT_W-1:0]      beat_cnt_r;
    logic [LAT_W-1:0]       lat_cnt_r;
    logic                   req_ready_r;
    logic                   data_ready_r;
    logic                   resp_valid_r;
    logic [DATA_BITS-1:0]   resp_data_r;
    logic [TAG_BITS-1:0]    resp_tag_r;
    logic [DATA_BITS-1:0]   mem_r [DEPTH];

    // Beat b of line A lives at (A*BEATS + b) mod DEPTH; upper line bits simply drop off.
    function automatic logic [IDX_W-1:0] line_index(input logic [ADDR_BITS-1:0] line,
                                                     input logic [BEAT_W-1:0]    beat);
        return IDX_W'({line, beat});
    endfunction

    assign mem_req_ready      = req_ready_r;
    assign mem_req_data_ready = data_ready_r;
    assign mem_resp_valid     = resp_valid_r;
    assign mem_resp_data      = resp_data_r;
    assign mem_resp_tag       = resp_tag_r;

    // Next-state decode and handshake strobes.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        wr_beat_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (mem_req_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = mem_req_rw ? WDATA : RWAIT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WDATA: begin
                if (mem_req_data_valid) begin
                    wr_beat_s = 1'b1;
                    if (beat_cnt_r == LAST_BEAT) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = WDATA;
                    end
                end else begin
                    state_next_s = WDATA;
                end
            end
            RWAIT: begin
                if (lat_cnt_r == {LAT_W{1'b0}}) begin
                    state_next_s = RRESP;
                end else begin
                    state_next_s = RWAIT;
                end
            end
            RRESP: begin
                if (beat_cnt_r == LAST_BEAT) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RRESP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Read side fetches beat 0 on leaving RWAIT, then the beat after the one on the bus.
    always_comb begin
        rd_beat_s = {BEAT_W{1'b0}};
        if (state_r == RRESP) begin
            rd_beat_s = beat_cnt_r + 1'b1;
        end else begin
            rd_beat_s = {BEAT_W{1'b0}};
        end
        rd_idx_s = line_index(addr_r, rd_beat_s);
        wr_idx_s = line_index(addr_r, beat_cnt_r);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Storage write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (!reset && wr_beat_s) begin
            for (int i = 0; i < BYTES; i++) begin
                if (mem_req_data_mask[i]) begin
                    mem_r[wr_idx_s][8*i +: 8] <= mem_req_data_bits[8*i +: 8];
                end
            end
        end
    end

    // Command latch, counters, handshake flags and registered response.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r       <= {ADDR_BITS{1'b0}};
            tag_r        <= {TAG_BITS{1'b0}};
            beat_cnt_r   <= {BEAT_W{1'b0}};
            lat_cnt_r    <= {LAT_W{1'b0}};
            req_ready_r  <= 1'b1;
            data_ready_r <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_data_r  <= {DATA_BITS{1'b0}};
            resp_tag_r   <= {TAG_BITS{1'b0}};
        end else begin
            req_ready_r  <= (state_next_s == IDLE);
            data_ready_r <= (state_next_s == WDATA);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        addr_r     <= mem_req_addr;
                        tag_r      <= mem_req_tag;
                        beat_cnt_r <= {BEAT_W{1'b0}};
                        lat_cnt_r  <= LAT_LOAD;
                    end
                end
                WDATA: begin
                    if (wr_beat_s) begin
                        beat_cnt_r <= beat_cnt_r + 1'b1;
                    end
                end
                RWAIT: begin
                    if (lat_cnt_r == {LAT_W{1'b0}}) begin
                        resp_valid_r <= 1'b1;
                        resp_data_r  <= mem_r[rd_idx_s];
                        resp_tag_r   <= tag_r;
                        beat_cnt_r   <= {BEAT_W{1'b0}};
                    end else begin
                        lat_cnt_r <= lat_cnt_r - 1'b1;
                    end
                end
                RRESP: begin
                    if (beat_cnt_r == LAST_BEAT) begin
                        resp_valid_r <= 1'b0;
                        beat_cnt_r   <= {BEAT_W{1'b0}};
                    end else begin
                        resp_data_r <= mem_r[rd_idx_s];
                        beat_cnt_r  <= rd_beat_s;
                    end
                end
                default: begin
                    resp_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
